// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the staggered reset sequencer.
// Also holds the helper that maps a domain index to its release edge.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_SOFT = 2'd1,
    CAUSE_WDT  = 2'd2
  } cause_e;

  typedef enum logic {
    ST_SEQ = 1'b0,
    ST_RUN = 1'b1
  } state_e;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_HOLD_CYCLES = 1;
  localparam int unsigned DEF_STAGGER     = 2;
  localparam int unsigned DEF_WDT_WIDTH   = 16;
  localparam int unsigned DEF_CNT_WIDTH   = 32;

  function automatic int unsigned release_edge(
    input int unsigned hold,
    input int unsigned stagger,
    input int unsigned idx
  );
    return hold + idx * stagger;
  endfunction

endpackage

// File: rtl/reset_sequencer_wdt_timer.sv
// Watchdog counter: counts while enabled, cleared by kick, clear or expiry.
// Expiry is flagged combinationally; the parent registers it.
module wdt_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             kick_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             active;

  assign active   = en_i && (limit_i != '0) && !clear_i;
  assign expire_o = active && !kick_i &&
                    (cnt_q == limit_i - WIDTH'(1));

  // A counter above a lowered limit simply keeps counting until it wraps.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (!active || kick_i || expire_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staggered multi-domain reset generator with soft reset and watchdog.
// Domains release one by one after a hold period; cause and uptime are reported.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned STAGGER     = DEF_STAGGER,
  parameter int unsigned WDT_WIDTH   = DEF_WDT_WIDTH,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 soft_rst_req,
  input  logic                 wdt_en,
  input  logic                 wdt_kick,
  input  logic [WDT_WIDTH-1:0] wdt_limit,
  output logic [NUM_CH-1:0]    ch_rst_n,
  output logic                 all_released,
  output logic                 wdt_fired,
  output logic [1:0]           reset_cause,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int unsigned LAST =
    HOLD_CYCLES + (NUM_CH - 1) * STAGGER;
  localparam int unsigned SW = $clog2(LAST + 1);

  state_e               state_q;
  cause_e               cause_q;
  logic [SW-1:0]        seq_q;
  logic [NUM_CH-1:0]    ch_q;
  logic                 all_q;
  logic                 fired_q;
  logic [CNT_WIDTH-1:0] cyc_q;

  logic [NUM_CH-1:0] rel;
  logic              last_edge;
  logic              wdt_exp;
  logic              wdt_clear;
  logic [31:0]       edge_k;

  // edge_k is the index of the SEQ edge currently being taken
  assign edge_k    = 32'(seq_q) + 32'd1;
  assign last_edge = (edge_k == LAST);
  assign wdt_clear = soft_rst_req || (state_q != ST_RUN);

  always_comb begin
    rel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rel[i] = edge_k >=
        release_edge(HOLD_CYCLES, STAGGER, i);
    end
  end

  wdt_timer #(
    .WIDTH (WDT_WIDTH)
  ) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (wdt_en),
    .kick_i   (wdt_kick),
    .clear_i  (wdt_clear),
    .limit_i  (wdt_limit),
    .expire_o (wdt_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SEQ;
      cause_q <= CAUSE_POR;
      seq_q   <= '0;
      ch_q    <= '0;
      all_q   <= 1'b0;
      fired_q <= 1'b0;
      cyc_q   <= '0;
    end else begin
      fired_q <= 1'b0;
      if (soft_rst_req || wdt_exp) begin
        state_q <= ST_SEQ;
        seq_q   <= '0;
        ch_q    <= '0;
        all_q   <= 1'b0;
        cyc_q   <= '0;
        cause_q <= soft_rst_req ? CAUSE_SOFT : CAUSE_WDT;
        fired_q <= !soft_rst_req;
      end else begin
        unique case (1'b1)
          state_q == ST_SEQ: begin
            seq_q <= seq_q + SW'(1);
            ch_q  <= ch_q | rel;
            if (last_edge) begin
              state_q <= ST_RUN;
              all_q   <= 1'b1;
            end
          end
          state_q == ST_RUN: begin
            if (cyc_q != '1) cyc_q <= cyc_q + CNT_WIDTH'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign ch_rst_n     = ch_q;
  assign all_released = all_q;
  assign wdt_fired    = fired_q;
  assign reset_cause  = cause_q;
  assign cycle_count  = cyc_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: event-time reference model, directed
// scenarios with literal pins, then a randomized soak.
module tb_reset_sequencer;

  localparam int NCH = 4, HOLD = 1, STG = 2;
  localparam int L1 = HOLD + (NCH - 1) * STG;
  localparam int HOLD2 = 3, L2 = 3;

  logic        clk, rst;
  logic        soft_rst_req, wdt_en, wdt_kick;
  logic [15:0] wdt_limit;
  logic [3:0]  ch_rst_n;
  logic        all_released, wdt_fired;
  logic [1:0]  reset_cause;
  logic [31:0] cycle_count;

  logic [0:0]  ch2;
  logic        all2, fired2;
  logic [1:0]  cause2;
  logic [31:0] cc2;

  int checks = 0, failures = 0;
  bit started = 0;

  reset_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .wdt_en       (wdt_en),
    .wdt_kick     (wdt_kick),
    .wdt_limit    (wdt_limit),
    .ch_rst_n     (ch_rst_n),
    .all_released (all_released),
    .wdt_fired    (wdt_fired),
    .reset_cause  (reset_cause),
    .cycle_count  (cycle_count)
  );

  reset_sequencer #(
    .NUM_CH      (1),
    .HOLD_CYCLES (3)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .wdt_en       (1'b0),
    .wdt_kick     (1'b0),
    .wdt_limit    (16'd0),
    .ch_rst_n     (ch2),
    .all_released (all2),
    .wdt_fired    (fired2),
    .reset_cause  (cause2),
    .cycle_count  (cc2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: k = edges since the last reset event; outputs follow from k.
  int         k, k2, wcnt;
  logic [1:0] m_cause, m_cause2;
  bit         m_fired;

  function automatic logic [3:0] m_ch(input int kk, input int hold,
                                      input int n);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = (kk >= hold + i * STG);
    return r;
  endfunction

  function automatic logic [31:0] m_cc(input int kk, input int last);
    return (kk > last) ? 32'(kk - last) : 32'd0;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit run, wexp, wact;
    if (rst) begin
      k = 0; k2 = 0; wcnt = 0;
      m_cause = 0; m_cause2 = 0; m_fired = 0;
    end else begin
      run  = (k >= L1);
      wact = run && wdt_en && (wdt_limit != 0);
      wexp = wact && !wdt_kick && (wcnt == int'(wdt_limit) - 1);
      if (soft_rst_req) begin
        k = 0; wcnt = 0; m_cause = 1; m_fired = 0;
      end else if (wexp) begin
        k = 0; wcnt = 0; m_cause = 2; m_fired = 1;
      end else begin
        m_fired = 0;
        wcnt = (wact && !wdt_kick) ? (wcnt + 1) % 65536 : 0;
        k++;
      end
      if (soft_rst_req) begin
        k2 = 0; m_cause2 = 1;
      end else begin
        k2++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ch_rst_n", ch_rst_n, m_ch(k, HOLD, NCH));
      chk("all_released", all_released, k >= L1);
      chk("wdt_fired", wdt_fired, m_fired);
      chk("reset_cause", reset_cause, m_cause);
      chk("cycle_count", cycle_count, m_cc(k, L1));
      chk("ch2", ch2, m_ch(k2, HOLD2, 1) & 4'h1);
      chk("all2", all2, k2 >= L2);
      chk("fired2", fired2, 1'b0);
      chk("cause2", cause2, m_cause2);
      chk("cc2", cc2, m_cc(k2, L2));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1; soft_rst_req = 0; wdt_en = 0;
    wdt_kick = 0; wdt_limit = 0;
    step(2);
    started = 1;
    chk("por_ch", ch_rst_n, 4'h0);
    chk("por_all", all_released, 1'b0);
    chk("por_cause", reset_cause, 2'd0);
    chk("por_cc", cycle_count, 32'd0);
    rst = 0;
    step(1);
    chk("e1_ch", ch_rst_n, 4'b0001);
    chk("e1_ch2", ch2, 1'b0);
    step(1);
    chk("e2_ch2", ch2, 1'b0);
    step(1);
    chk("e3_ch", ch_rst_n, 4'b0011);
    chk("e3_ch2", ch2, 1'b1);
    chk("e3_all2", all2, 1'b1);
    step(2);
    chk("e5_ch", ch_rst_n, 4'b0111);
    chk("e5_all", all_released, 1'b0);
    step(2);
    chk("e7_ch", ch_rst_n, 4'b1111);
    chk("e7_all", all_released, 1'b1);
    step(4);
    chk("run4_cc", cycle_count, 32'd4);

    // soft reset on RUN edge 5, watchdog armed at the same time
    soft_rst_req = 1; wdt_en = 1; wdt_limit = 3;
    step(1);
    soft_rst_req = 0;
    chk("soft_ch", ch_rst_n, 4'h0);
    chk("soft_cc", cycle_count, 32'd0);
    chk("soft_cause", reset_cause, 2'd1);
    step(7);
    chk("soft_rel", all_released, 1'b1);
    step(3);
    chk("wdt_fire", wdt_fired, 1'b1);
    chk("wdt_ch", ch_rst_n, 4'h0);
    chk("wdt_cause", reset_cause, 2'd2);
    step(1);
    chk("wdt_pulse", wdt_fired, 1'b0);
    step(6);
    chk("wdt_rel", all_released, 1'b1);

    for (int c = 1; c <= 100; c++) begin
      wdt_kick = (c % 2 == 0);
      step(1);
    end
    wdt_kick = 0;
    chk("kick_cc", cycle_count, 32'd100);

    step(2);
    soft_rst_req = 1;
    step(1);
    soft_rst_req = 0;
    chk("both_cause", reset_cause, 2'd1);
    chk("both_fired", wdt_fired, 1'b0);

    step(7);
    step(2);
    wdt_kick = 1;
    step(1);
    wdt_kick = 0;
    chk("kick_exp_fired", wdt_fired, 1'b0);
    chk("kick_exp_all", all_released, 1'b1);

    wdt_en = 0;
    soft_rst_req = 1;
    step(1);
    soft_rst_req = 0;
    step(4);
    #1 rst = 1;
    #1;
    chk("arst_ch", ch_rst_n, 4'h0);
    chk("arst_all", all_released, 1'b0);
    chk("arst_cause", reset_cause, 2'd0);
    @(negedge clk);
    rst = 0;
    step(7);
    chk("arst_rel", ch_rst_n, 4'hf);

    for (int n = 0; n < 3000; n++) begin
      soft_rst_req = ($urandom_range(0, 99) < 2);
      wdt_en       = ($urandom_range(0, 9) != 0);
      wdt_kick     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0)
        wdt_limit = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1;
        @(negedge clk);
        rst = 0;
      end else begin
        step(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
